shift_sequencer: RTL

//   Multi-cycle arithmetic-right-shift unit for the accumulator datapath. Takes an

---
 rtl/shift_sequencer.sv | 85 ++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle arithmetic right shifter: one sign-preserving divide-by-2 step per clock,
// returning the quotient, the last bit shifted out of bit 0 and a zero flag.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while busy=0. operand/shamt are captured on that
  // edge and may then change. done pulses for one cycle with result/cout/zero valid,
  // and the results hold through the following idle cycles until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = operand;
          cnt_d   = shamt;
          cout_d  = 1'b0;
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Replicating the sign bit floors toward minus infinity.
        cout_d = acc_q[0];
        acc_d  = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = acc_q;
  assign cout      = cout_q;
  assign zero      = (acc_q == '0);
  assign dbg_state = state_q;

endmodule
